// File: rtl/mem_pkg.sv
// Shared types and constants for the pipelined memory responder.
package mem_pkg;

   localparam int MEM_WORD_WIDTH  = 16;
   localparam int MEM_MAX_LATENCY = 8;

   typedef struct packed {
      logic                      valid;
      logic [MEM_WORD_WIDTH-1:0] data;
      logic                      err;
   } mem_stage_t;

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side memory request/response bundle.
// The err signal exists only when MEM_ALIGN_CHECK_EN is defined.
interface mem_responder_if #(
   parameter int ADDR_WIDTH = 16
);
   import mem_pkg::*;

   logic                      enable;
   logic                      wr;
   logic [ADDR_WIDTH-1:0]     addr;
   logic [MEM_WORD_WIDTH-1:0] data_in;
   logic [MEM_WORD_WIDTH-1:0] data_out;
   logic                      data_valid;
`ifdef MEM_ALIGN_CHECK_EN
   logic                      err;

   modport master (
      output enable, wr, addr, data_in,
      input  data_out, data_valid, err
   );
   modport slave (
      input  enable, wr, addr, data_in,
      output data_out, data_valid, err
   );
`else
   modport master (
      output enable, wr, addr, data_in,
      input  data_out, data_valid
   );
   modport slave (
      input  enable, wr, addr, data_in,
      output data_out, data_valid
   );
`endif

endinterface

// File: rtl/mem_delay_line.sv
// Fixed-depth shift register of pipeline stages.
// Synchronous clear on rst.
module mem_delay_line
   import mem_pkg::*;
#(
   parameter int LATENCY = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  mem_stage_t d,
   output mem_stage_t q
);

   mem_stage_t pipe [LATENCY];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= d;
         for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign q = pipe[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Pipelined memory model: one request per cycle, reads return LATENCY later.
// Optional misalignment checking with MEM_ALIGN_CHECK_EN.
module mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int LATENCY    = 4
) (
   input logic            clk,
   input logic            rst,
   mem_responder_if.slave bus
);

   localparam int DEPTH = 2 ** (ADDR_WIDTH - 1);

   logic [MEM_WORD_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-2:0]     idx;
   logic                      mis;
   logic                      accept;
   logic                      do_wr;
   logic                      do_rd;
   mem_stage_t                head;
   mem_stage_t                tail;

   generate
      if (LATENCY < 1 || LATENCY > MEM_MAX_LATENCY) begin : g_bad_latency
         $error("mem_responder: LATENCY %0d outside 1..%0d",
                LATENCY, MEM_MAX_LATENCY);
      end
   endgenerate

   assign idx = bus.addr[ADDR_WIDTH-1:1];

`ifdef MEM_ALIGN_CHECK_EN
   assign mis = bus.addr[0];
`else
   logic unused_bits;
   assign mis         = 1'b0;
   assign unused_bits = ^{bus.addr[0], tail.err};
`endif

   assign accept = bus.enable & ~rst;
   assign do_wr  = accept & bus.wr & ~mis;
   assign do_rd  = accept & ~bus.wr;

   always_ff @(posedge clk) begin
      if (do_wr) mem[idx] <= bus.data_in;
   end

   // Idle stages carry zero data so data_out reads 0 between responses.
   always_comb begin
      head = '0;
      if (do_rd) begin
         head.valid = 1'b1;
         head.err   = mis;
         head.data  = mis ? '0 : mem[idx];
      end
   end

   mem_delay_line #(
      .LATENCY(LATENCY)
   ) u_delay (
      .clk(clk),
      .rst(rst),
      .d  (head),
      .q  (tail)
   );

   assign bus.data_out   = tail.data;
   assign bus.data_valid = tail.valid;

`ifdef MEM_ALIGN_CHECK_EN
   logic wr_err_q;

   always_ff @(posedge clk) begin
      if (rst) wr_err_q <= 1'b0;
      else     wr_err_q <= accept & bus.wr & mis;
   end

   assign bus.err = tail.err | wr_err_q;
`endif

   a_wr_known: assert property (
      @(posedge clk) disable iff (rst) bus.enable |-> !$isunknown(bus.wr)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Randomized + directed bench for mem_responder at LATENCY 4 and 1.
// Define MEM_ALIGN_CHECK_EN to exercise misalignment checking.
module tb_mem_responder;
   import mem_pkg::*;

   localparam int AW = 16;
`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   typedef struct {
      int          due;
      logic [15:0] data;
      bit          known;
      bit          err;
   } resp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_responder_if #(.ADDR_WIDTH(AW)) bus4 ();
   mem_responder_if #(.ADDR_WIDTH(AW)) bus1 ();

   mem_responder #(.ADDR_WIDTH(AW), .LATENCY(4)) dut4 (
      .clk(clk), .rst(rst), .bus(bus4.slave)
   );
   mem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave)
   );

   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;
   logic [15:0] mem_m [int];
   resp_t       q [2][$];
   bit          werr_now;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d",
                  tag, obs, exp, cyc);
      end
   endtask

   task automatic judge(int k, logic v, logic [15:0] d, logic e);
      bit    ev;
      resp_t r;
      string n;
      n  = (k == 0) ? "lat4" : "lat1";
      ev = (q[k].size() > 0) && (q[k][0].due == cyc);
      check({n, " valid"}, {31'd0, v}, {31'd0, ev});
      if (ev) begin
         r = q[k].pop_front();
         if (r.known) check({n, " data"}, {16'd0, d}, {16'd0, r.data});
      end else begin
         r.err = 1'b0;
         check({n, " idle data"}, {16'd0, d}, 32'd0);
      end
      if (ALIGN) check({n, " err"}, {31'd0, e}, {31'd0, (ev && r.err) || werr_now});
   endtask

   task automatic step(bit r, bit en, bit w, logic [15:0] a, logic [15:0] d);
      int    idx;
      bit    mis;
      resp_t rp;
      @(negedge clk);
      rst          = r;
      bus4.enable  = en; bus4.wr = w; bus4.addr = a; bus4.data_in = d;
      bus1.enable  = en; bus1.wr = w; bus1.addr = a; bus1.data_in = d;
      @(posedge clk);
      cyc++;
      idx      = int'(a >> 1);
      mis      = ALIGN && a[0];
      werr_now = 1'b0;
      if (r) begin
         q[0].delete();
         q[1].delete();
      end else if (en) begin
         if (w) begin
            if (mis) werr_now = 1'b1;
            else     mem_m[idx] = d;
         end else begin
            rp.err   = mis;
            rp.known = mis || mem_m.exists(idx);
            rp.data  = mis ? 16'h0000 : (mem_m.exists(idx) ? mem_m[idx] : 16'h0);
            rp.due   = cyc + 3;
            q[0].push_back(rp);
            rp.due   = cyc;
            q[1].push_back(rp);
         end
      end
      #1;
`ifdef MEM_ALIGN_CHECK_EN
      judge(0, bus4.data_valid, bus4.data_out, bus4.err);
      judge(1, bus1.data_valid, bus1.data_out, bus1.err);
`else
      judge(0, bus4.data_valid, bus4.data_out, 1'b0);
      judge(1, bus1.data_valid, bus1.data_out, 1'b0);
`endif
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 16'h0);
   endtask

   initial begin
      bus4.enable = 0; bus4.wr = 0; bus4.addr = '0; bus4.data_in = '0;
      bus1.enable = 0; bus1.wr = 0; bus1.addr = '0; bus1.data_in = '0;

      // reset; a request alongside rst must be dropped
      step(1, 0, 0, 16'h0, 16'h0);
      step(1, 1, 1, 16'h0040, 16'hDEAD);
      step(1, 1, 0, 16'h0040, 16'h0);
      idle(5);

      // write then read
      step(0, 1, 1, 16'h0010, 16'hBEEF);
      step(0, 1, 0, 16'h0010, 16'h0);
      idle(5);

      // streaming reads
      for (int i = 0; i < 4; i++) step(0, 1, 1, 16'(2 * i), 16'(i + 1));
      for (int i = 0; i < 4; i++) step(0, 1, 0, 16'(2 * i), 16'h0);
      idle(5);

      // write under read
      step(0, 1, 1, 16'h0020, 16'h1111);
      step(0, 1, 0, 16'h0020, 16'h0);
      step(0, 1, 1, 16'h0020, 16'h2222);
      step(0, 1, 0, 16'h0020, 16'h0);
      idle(5);

      // reset mid-flight
      step(0, 1, 0, 16'h0010, 16'h0);
      step(0, 1, 0, 16'h0000, 16'h0);
      step(1, 1, 0, 16'h0002, 16'h0);
      idle(6);
      step(0, 1, 0, 16'h0010, 16'h0);
      idle(5);

      // top-of-array word
      step(0, 1, 1, 16'hFFFE, 16'hA5A5);
      step(0, 1, 0, 16'hFFFE, 16'h0);
      idle(5);

      if (ALIGN) begin
         step(0, 1, 1, 16'h0030, 16'h5555);
         step(0, 1, 1, 16'h0031, 16'h1234);
         step(0, 1, 0, 16'h0030, 16'h0);
         step(0, 1, 0, 16'h0031, 16'h0);
         idle(5);
      end

      // random traffic
      for (int i = 0; i < 600; i++) begin
         logic [15:0] a;
         bit          r;
         a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 63))
                                         : 16'($urandom);
         r = ($urandom_range(0, 49) == 0);
         step(r, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
              a, 16'($urandom));
      end
      idle(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
